wdata_issue_ctrl: RTL

- Sequences pops from the write-data FIFO onto the DRAM DQ output path. Each pop is timed to the write latency of the WRITE command that the command scheduler has just issued.
- Sits between the write-data FIFO (pop side) and the PHY DQ/DQS drivers. It receives a one-cycle issue strobe per WRITE command.
- Tracks overlapping in-flight bursts, drives DQ output-enable and DQS enable, and flags underrun and command-spacing errors.

---
 rtl/ddr_wr_pkg.sv | 28 ++
 rtl/wr_launch_delay.sv | 48 ++++
 rtl/wdata_issue_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ddr_wr_pkg.sv
// Shared types and defaults for the DRAM write-data issue path.
package ddr_wr_pkg;

  // Width of one write-data FIFO word / one DQ beat group.
  localparam int unsigned DATA_W_DEF = 128;
  // Controller-clock beats per burst (BL8 at 2:1).
  localparam int unsigned BEATS_DEF  = 4;
  // Largest supported write latency in controller cycles.
  localparam int unsigned WL_MAX_DEF = 16;
  // Width of the write-latency configuration field.
  localparam int unsigned WL_W       = 5;
  // Width of the beat counter for the default burst length.
  localparam int unsigned BEAT_W     = $clog2(BEATS_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  // Force a raw write latency into the supported range 2..wl_max.
  function automatic logic [WL_W-1:0] clamp_wl(input logic [WL_W-1:0] v,
                                               input int unsigned    wl_max);
    if (v < WL_W'(2)) return WL_W'(2);
    if (32'(v) > wl_max) return WL_W'(wl_max);
    return v;
  endfunction

endpackage

// File: rtl/wr_launch_delay.sv
// Write-latency delay line: an accepted WRITE issue plants a token that
// reaches the tap (bit 0) exactly WL-2 cycles later, one cycle ahead of the
// first FIFO pop so the DQS preamble can be registered in time.
module wr_launch_delay
  import ddr_wr_pkg::*;
#(
  parameter int unsigned WL_MAX = WL_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [WL_W-1:0] wl,
  output logic            launch,
  output logic            pending
);

  logic [WL_MAX-1:0] line_q;
  logic [WL_MAX-1:0] line_d;
  logic [WL_MAX-1:0] load_vec;

  // Shift tokens toward the tap and insert a new one at the WL-dependent slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    load_vec = '0;
    for (int i = 0; i < int'(WL_MAX); i++) begin
      if (load && (int'(wl) == i + 3)) load_vec[i] = 1'b1;
    end
    line_d = (line_q >> 1) | load_vec;
  end

  // With WL=2 the launch must happen in the issue cycle itself, so the tap
  // is bypassed and the issue drives launch directly.
  assign launch  = line_q[0] | (load && (wl == WL_W'(2)));
  assign pending = |line_q;

  // Delay-line state; cleared on reset so an aborted burst leaves no tokens.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/wdata_issue_ctrl.sv
// Write-data issue controller: times FIFO pops to the write latency of each
// WRITE command and drives registered DQ data, DQ output enable and DQS
// enable (with a one-cycle preamble) toward the PHY.
module wdata_issue_ctrl
  import ddr_wr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BEATS  = BEATS_DEF,
  parameter int unsigned WL_MAX = WL_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WL_W-1:0]   cfg_wl,
  input  logic              wr_cmd_issue,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_ren,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              dqs_en,
  output logic              wr_busy,
  output logic              cmd_err,
  output logic              underrun_err
);

  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Spacing counter must be able to hold the value BEATS itself.
  localparam int unsigned SP_W   = $clog2(BEATS + 1);

  burst_state_e      state_q;
  logic [BCNT_W-1:0] beat_q;
  logic [WL_W-1:0]   wl_q;
  logic [WL_W-1:0]   wl_d;
  logic [SP_W-1:0]   space_q;
  logic [DATA_W-1:0] dq_out_q;
  logic              dq_oe_q;
  logic              dqs_en_q;
  logic              cmd_err_q;
  logic              underrun_err_q;

  logic              issue_ok;
  logic              launch;
  logic              line_pending;
  logic              in_burst;
  logic              beat_last;

  assign in_burst  = (state_q == BURST);
  assign beat_last = (beat_q == BCNT_W'(BEATS - 1));

  // Anything still in flight: a token in the delay line, an active burst, or
  // the final registered beat still on the bus.
  assign wr_busy = line_pending | in_burst | dq_oe_q;

  // Latency follows cfg_wl only while idle, so all in-flight bursts share one
  // WL and can never collide inside the delay line.
  assign wl_d = wr_busy ? wl_q : clamp_wl(cfg_wl, WL_MAX);

  // Issues closer than one burst length to the previous accepted issue would
  // overlap on DQ; they are dropped and flagged instead.
  assign issue_ok = wr_cmd_issue && (space_q >= SP_W'(BEATS));

  // Never pop an empty FIFO; the beat is still consumed as an underrun.
  assign fifo_ren = in_burst && !fifo_empty;

  wr_launch_delay #(
    .WL_MAX (WL_MAX)
  ) u_launch_delay (
    .clk     (clk),
    .rst     (rst),
    .load    (issue_ok),
    .wl      (wl_d),
    .launch  (launch),
    .pending (line_pending)
  );

  // Burst FSM, issue-spacing tracking, sticky errors and registered PHY outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      wl_q           <= WL_W'(2);
      space_q        <= SP_W'(BEATS);
      dq_out_q       <= '0;
      dq_oe_q        <= 1'b0;
      dqs_en_q       <= 1'b0;
      cmd_err_q      <= 1'b0;
      underrun_err_q <= 1'b0;
    end else begin
      wl_q <= wl_d;

      // Cycles since the last accepted issue, saturating at one burst length.
      if (issue_ok) begin
        space_q <= SP_W'(1);
      end else if (space_q != SP_W'(BEATS)) begin
        space_q <= space_q + SP_W'(1);
      end

      if (wr_cmd_issue && !issue_ok) cmd_err_q <= 1'b1;
      if (in_burst && fifo_empty)    underrun_err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= BURST;
            beat_q  <= '0;
          end
        end
        BURST: begin
          if (beat_last) begin
            // A launch landing on the last beat continues seamlessly.
            state_q <= launch ? BURST : IDLE;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + BCNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
      endcase

      // Data and OE trail the pop by one cycle; DQS also opens one cycle
      // early (on launch) to form the preamble.
      dq_out_q <= fifo_ren ? fifo_data : '0;
      dq_oe_q  <= in_burst;
      dqs_en_q <= launch | in_burst;
    end
  end

  assign dq_out       = dq_out_q;
  assign dq_oe        = dq_oe_q;
  assign dqs_en       = dqs_en_q;
  assign cmd_err      = cmd_err_q;
  assign underrun_err = underrun_err_q;

endmodule
